pipe_skid_reg: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer, flush-to-bubble and a saturating stall counter. One instance sits at each boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). A stage can stall without a combinational ready path back through the pipe. Flush kills in-flight instructions by forcing their control fields to a bubble value. This replaces the fixed-field, load-enable-only stage registers.

---
 rtl/pipe_skid_reg.sv | 104 ++++++++++
 tb/tb_pipe_skid_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - pipeline stage register with two-entry skid buffer, flush-to-bubble and stall counter
// in_ready is taken straight from the skid-valid flop, so no combinational path runs from out_ready.
module pipe_skid_reg #(
  parameter int                 DATA_W      = 96,
  parameter int                 CTRL_W      = 24,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Occupancy encoded as {s_valid, m_valid}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic              m_valid;
  logic              s_valid;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic [CTRL_W-1:0] s_ctrl;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        state;
  logic              accept;
  logic              fire;

  assign state     = {s_valid, m_valid};
  assign in_ready  = ~s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : BUBBLE_CTRL;
  assign stall_cnt = cnt;
  assign accept    = in_valid & ~s_valid;
  assign fire      = m_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
      m_ctrl  <= BUBBLE_CTRL;
      s_ctrl  <= BUBBLE_CTRL;
    end else if (flush) begin
      // Payload registers keep stale contents; only validity is killed.
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
            m_ctrl  <= in_ctrl;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            m_data <= in_data;
            m_ctrl <= in_ctrl;
          end else if (accept) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
            s_ctrl  <= in_ctrl;
          end else if (fire) begin
            m_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (fire) begin
            m_data  <= s_data;
            m_ctrl  <= s_ctrl;
            s_valid <= 1'b0;
          end
        end
        default: begin
          m_valid <= 1'b0;
          s_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (m_valid && !out_ready && !(&cnt)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - queue-model bench for pipe_skid_reg with directed scenarios
module tb_pipe_skid_reg;

  localparam int              DW     = 96;
  localparam int              CW     = 24;
  localparam int              NW     = 4;
  localparam logic [CW-1:0]   BUBBLE = 24'h5A5A5A;
  localparam logic [CW-1:0]   CT     = 24'h00ABC;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] stall_cnt;

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUBBLE), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: the stage is a FIFO of capacity two; the head is what is presented.
  typedef struct packed {logic [DW-1:0] d; logic [CW-1:0] c;} ent_t;
  ent_t          q[$];
  ent_t          e;
  logic [DW-1:0] m_data_mdl = '0;
  int            cnt_mdl = 0;
  bit            acc_mdl, fire_mdl;
  bit            mdl_en = 1'b0;

  always @(posedge clk) begin
    acc_mdl  = in_valid && (q.size() < 2);
    fire_mdl = (q.size() > 0) && out_ready;
    if (reset) begin
      q.delete();
      m_data_mdl = '0;
      cnt_mdl = 0;
    end else begin
      if (q.size() > 0 && !out_ready && cnt_mdl < (2**NW - 1)) cnt_mdl++;
      if (fire_mdl) void'(q.pop_front());
      if (flush) q.delete();
      else if (acc_mdl) begin
        e.d = in_data;
        e.c = in_ctrl;
        q.push_back(e);
      end
      if (q.size() > 0) m_data_mdl = q[0].d;
    end
  end

  always @(negedge clk) begin
    if (mdl_en) begin
      chk("m_out_valid", out_valid, q.size() > 0);
      chk("m_in_ready", in_ready, q.size() < 2);
      chk("m_out_data", out_data, m_data_mdl);
      chk("m_out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : BUBBLE);
      chk("m_stall_cnt", stall_cnt, cnt_mdl);
    end
  end

  // Every instruction the consumer actually takes
  logic [DW-1:0] dlog[$];
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) dlog.push_back(out_data);
  end

  task automatic cyc(input bit r, input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input bit f, input bit o);
    reset = r; in_valid = v; in_data = d; in_ctrl = c; flush = f; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit o, input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, '0, 1'b0, o);
  endtask

  initial begin
    // Reset values
    cyc(1'b1, 1'b1, 96'h77, CT, 1'b0, 1'b1);
    mdl_en = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 96'h0);
    chk("rst_out_ctrl", out_ctrl, BUBBLE);
    chk("rst_stall_cnt", stall_cnt, 4'd0);

    // Streaming at full throughput
    dlog.delete();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, DW'(i), CT, 1'b0, 1'b1);
      if (i == 1) begin
        chk("stream_first_valid", out_valid, 1'b1);
        chk("stream_first_data", out_data, 96'h1);
        chk("stream_first_ctrl", out_ctrl, CT);
      end
      chk("stream_in_ready", in_ready, 1'b1);
    end
    idle(1'b1, 2);
    chk("stream_count", dlog.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < dlog.size()) chk("stream_order", dlog[i], DW'(i + 1));
    chk("stream_stall", stall_cnt, 4'd0);

    // Stall absorption into the skid entry
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    dlog.delete();
    cyc(1'b0, 1'b1, 96'hA, 24'h0000A1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 96'hB, 24'h0000B2, 1'b0, 1'b0);
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_hold_data", out_data, 96'hA);
    chk("stall_cnt1", stall_cnt, 4'd1);
    idle(1'b0, 1);
    chk("stall_cnt2", stall_cnt, 4'd2);
    idle(1'b0, 1);
    chk("stall_cnt3", stall_cnt, 4'd3);
    idle(1'b1, 1);
    chk("stall_ready_back", in_ready, 1'b1);
    chk("stall_skid_to_main", out_ctrl, 24'h0000B2);
    idle(1'b1, 2);
    chk("stall_count", dlog.size(), 2);
    if (dlog.size() == 2) begin
      chk("stall_first", dlog[0], 96'hA);
      chk("stall_second", dlog[1], 96'hB);
    end

    // Flush while full
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    dlog.delete();
    cyc(1'b0, 1'b1, 96'hC, CT, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 96'hD, CT, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 96'hE, CT, 1'b1, 1'b0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_out_ctrl", out_ctrl, BUBBLE);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_keeps_cnt", stall_cnt, 4'd2);
    idle(1'b1, 3);
    chk("flush_nothing_out", dlog.size(), 0);

    // Flush coinciding with a fire in ONE
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    dlog.delete();
    cyc(1'b0, 1'b1, 96'hF, CT, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 96'h10, CT, 1'b1, 1'b1);
    chk("flfire_empty", out_valid, 1'b0);
    idle(1'b1, 3);
    chk("flfire_count", dlog.size(), 1);
    if (dlog.size() == 1) chk("flfire_data", dlog[0], 96'hF);

    // Stall counter saturation
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 96'h20, CT, 1'b0, 1'b0);
    idle(1'b0, 20);
    chk("sat_cnt", stall_cnt, 4'd15);

    // Reset while full with both handshakes asserted
    cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    dlog.delete();
    cyc(1'b0, 1'b1, 96'h30, CT, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 96'h31, CT, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 96'h32, CT, 1'b1, 1'b1);
    chk("rstfull_out_valid", out_valid, 1'b0);
    chk("rstfull_in_ready", in_ready, 1'b1);
    chk("rstfull_out_data", out_data, 96'h0);
    chk("rstfull_out_ctrl", out_ctrl, BUBBLE);
    chk("rstfull_stall", stall_cnt, 4'd0);
    idle(1'b1, 2);
    chk("rstfull_no_xfer", dlog.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
